// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and dmem_ctrl (slave).
`timescale 1ns/1ps
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-lane data memory with sub-word loads, fault detection, post-reset clear
// sweep and a fixed-latency response pipe.
`timescale 1ns/1ps
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LATENCY  = 1,
  parameter int CLEAR_EN    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  bus,
  output logic        init_busy_o
);
  localparam int AW       = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  state_e                         state_q;
  logic [AW-1:0]                  cnt_q;
  logic                           ready_q;
  logic                           busy_q;
  logic [NUM_LANES-1:0][7:0]      mem_q [DEPTH_WORDS];
  logic [RD_LATENCY:0]            vld_pipe;
  rsp_t [RD_LATENCY:0]            rsp_pipe;

  logic                           accept;
  logic [AW-1:0]                  idx;
  logic [1:0]                     off;
  logic                           fault;
  logic [NUM_LANES-1:0]           be;
  logic [NUM_LANES-1:0][7:0]      wlane;
  logic [NUM_LANES-1:0][7:0]      rd_word;
  logic [7:0]                     rd_byte;
  logic [15:0]                    rd_half;
  logic [31:0]                    ld_data;
  rsp_t                           rsp_d;

  assign accept  = bus.req_valid & ready_q;
  assign idx     = bus.req_addr[AW+1:2];
  assign off     = bus.req_addr[1:0];
  assign rd_word = mem_q[idx];
  assign rd_byte = rd_word[off];
  assign rd_half = off[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};

  always_comb begin
    fault = 1'b0;
    case (bus.req_size)
      2'b01:   fault = off[0];
      2'b10:   fault = (off != 2'b00);
      2'b11:   fault = 1'b1;
      default: fault = 1'b0;
    endcase
    if (bus.req_addr[31:AW+2] != '0) fault = 1'b1;
  end

  // Store data is replicated across lanes so each lane only needs its enable.
  always_comb begin
    be    = '0;
    wlane = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      case (bus.req_size)
        2'b00: begin
          be[l]    = (off == 2'(l));
          wlane[l] = bus.req_wdata[7:0];
        end
        2'b01: begin
          be[l]    = (off[1] == l[1]);
          wlane[l] = l[0] ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
        end
        default: begin
          be[l]    = 1'b1;
          wlane[l] = bus.req_wdata[8*l +: 8];
        end
      endcase
    end
  end

  always_comb begin
    case (bus.req_size)
      2'b00:   ld_data = {{24{~bus.req_unsigned & rd_byte[7]}}, rd_byte};
      2'b01:   ld_data = {{16{~bus.req_unsigned & rd_half[15]}}, rd_half};
      default: ld_data = rd_word;
    endcase
    rsp_d.err   = accept & fault;
    rsp_d.rdata = (accept && !bus.req_we && !fault) ? ld_data : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_EN != 0) ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= (CLEAR_EN != 0);
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; the sweep is what makes it defined.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (accept && bus.req_we && !fault) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (be[l]) mem_q[idx][l] <= wlane[l];
    end
  end

  // Stage 0 captures at the accept edge; stage RD_LATENCY drives the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rsp_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      rsp_pipe[0] <= rsp_d;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        rsp_pipe[i] <= rsp_pipe[i-1];
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = vld_pipe[RD_LATENCY];
  assign bus.rsp_rdata = rsp_pipe[RD_LATENCY].rdata;
  assign bus.rsp_err   = rsp_pipe[RD_LATENCY].err;
  assign init_busy_o   = busy_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: expectations queued at issue, checked on rsp_valid.
`timescale 1ns/1ps
module tb_dmem_ctrl;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic init_busy;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       tag;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_ctrl_if bus();

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT), .CLEAR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .init_busy_o(init_busy)
  );

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h with nothing outstanding", bus.rsp_rdata);
      end else begin
        mon_e = sb.pop_front();
        n_cmp++;
        if (bus.rsp_rdata !== mon_e.rdata) begin
          n_bad++;
          $display("FAIL %s_rdata: got %h want %h", mon_e.tag, bus.rsp_rdata, mon_e.rdata);
        end
        n_cmp++;
        if (bus.rsp_err !== mon_e.err) begin
          n_bad++;
          $display("FAIL %s_err: got %b want %b", mon_e.tag, bus.rsp_err, mon_e.err);
        end
        n_cmp++;
        if (cyc - mon_e.acc !== LAT) begin
          n_bad++;
          $display("FAIL %s_latency: got %0d want %0d", mon_e.tag, cyc - mon_e.acc, LAT);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int   w = 0;
    exp_t e;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    while (bus.req_ready !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
    if (w >= 2000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_accept_timeout: req_ready=%b want 1", tag, bus.req_ready);
      bus.req_valid = 1'b0;
    end else begin
      e.rdata = exp_rd; e.err = exp_err; e.acc = cyc + 1; e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic idle();
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    idle();
    while (sb.size() != 0 && w < 20) begin @(negedge clk); w++; end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_missing: %0d responses outstanding want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic count_sweep(input string tag);
    int n = 0;
    while (init_busy === 1'b1 && n < 1000) begin n++; @(negedge clk); end
    n_cmp++;
    if (n != DEPTH) begin n_bad++; $display("FAIL %s_busy_cycles: got %0d want %0d", tag, n, DEPTH); end
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready_after: got %b want 1", tag, bus.req_ready); end
  endtask

  task automatic test_reset();
    idle(); bus.req_size = 2'b10; bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_cmp++;
    if (bus.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    n_cmp++;
    if (bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    n_cmp++;
    if (init_busy !== 1'b1) begin n_bad++; $display("FAIL reset_init_busy: got %b want 1", init_busy); end
    rst_n = 1'b1;
    count_sweep("sweep");
  endtask

  task automatic test_sweep_zero();
    for (int i = 0; i < DEPTH; i++)
      issue(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0, 32'h0, 1'b0, "sweep_ld");
    drain();
  endtask

  task automatic test_store_lanes();
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 32'h0, 1'b0, "sb11");
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "lw10");
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb13");
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, "lbu13");
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h00000055, 1'b0, "lb11");
    drain();
  endtask

  task automatic test_half();
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'hCAFE8001, 32'h0, 1'b0, "sh22");
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, "lh22");
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h00008001, 1'b0, "lhu22");
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h80010000, 1'b0, "lw20");
    drain();
  endtask

  task automatic test_faults();
    issue(1'b1, 2'b10, 1'b0, 32'h04, 32'h11223344, 32'h0, 1'b0, "sw04");
    issue(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1, "lw02_mis");
    issue(1'b1, 2'b01, 1'b0, 32'h05, 32'h0000BEEF, 32'h0, 1'b1, "sh05_mis");
    issue(1'b1, 2'b11, 1'b0, 32'h04, 32'hFFFFFFFF, 32'h0, 1'b1, "st_sz11");
    issue(1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 32'h0, 1'b1, "ld_sz11");
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, "lw400_oor");
    issue(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0, 1'b1, "sw400_oor");
    issue(1'b0, 2'b10, 1'b0, 32'h80000000, 32'h0, 32'h0, 1'b1, "lw_hi_oor");
    issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h11223344, 1'b0, "lw04_kept");
    issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, "lw00_kept");
    drain();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "b2b0");
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h80010000, 1'b0, "b2b1");
    issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h11223344, 1'b0, "b2b2");
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h000000EF, 1'b0, "b2b3");
    drain();
  endtask

  task automatic test_reset_inflight();
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, "fl0");
    issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h11223344, 1'b0, "fl1");
    idle();
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL inflight_rsp_valid: got %b want 0", bus.rsp_valid); end
      n_cmp++;
      if (init_busy !== 1'b1) begin n_bad++; $display("FAIL inflight_init_busy: got %b want 1", init_busy); end
    end
    rst_n = 1'b1;
    count_sweep("resweep");
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, "lw10_cleared");
    issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, "lw04_cleared");
    drain();
  endtask

  initial begin
    test_reset();
    test_sweep_zero();
    test_store_lanes();
    test_half();
    test_faults();
    test_back_to_back();
    test_reset_inflight();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
